// File: rtl/pipe_pkg.sv
// Shared definitions for the inter-stage pipeline buffers: payload widths,
// field offsets for packing stage bundles, and occupancy encodings.
package pipe_pkg;

  localparam int XLEN   = 32;
  localparam int PC_W   = 32;
  localparam int INST_W = 32;
  localparam int REG_W  = 5;
  localparam int CTRL_W = 16;

  localparam int IF_ID_W  = PC_W + INST_W;
  localparam int ID_EX_W  = PC_W + 2 * XLEN + REG_W + CTRL_W;
  localparam int EX_MEM_W = 2 * XLEN + REG_W + CTRL_W;
  localparam int MEM_WB_W = XLEN + REG_W + CTRL_W;

  // Fields are packed from bit 0 upward in the order listed.
  localparam int IF_ID_PC_LSB   = 0;
  localparam int IF_ID_INST_LSB = IF_ID_PC_LSB + PC_W;

  localparam int ID_EX_CTRL_LSB = 0;
  localparam int ID_EX_RD_LSB   = ID_EX_CTRL_LSB + CTRL_W;
  localparam int ID_EX_RS2_LSB  = ID_EX_RD_LSB + REG_W;
  localparam int ID_EX_RS1_LSB  = ID_EX_RS2_LSB + XLEN;
  localparam int ID_EX_PC_LSB   = ID_EX_RS1_LSB + XLEN;

  localparam int EX_MEM_CTRL_LSB = 0;
  localparam int EX_MEM_RD_LSB   = EX_MEM_CTRL_LSB + CTRL_W;
  localparam int EX_MEM_STV_LSB  = EX_MEM_RD_LSB + REG_W;
  localparam int EX_MEM_ALU_LSB  = EX_MEM_STV_LSB + XLEN;

  localparam int MEM_WB_CTRL_LSB = 0;
  localparam int MEM_WB_RD_LSB   = MEM_WB_CTRL_LSB + CTRL_W;
  localparam int MEM_WB_RES_LSB  = MEM_WB_RD_LSB + REG_W;

  localparam logic [1:0] OCC_EMPTY = 2'd0;
  localparam logic [1:0] OCC_ONE   = 2'd1;
  localparam logic [1:0] OCC_FULL  = 2'd2;

endpackage

// File: rtl/pipe_skid_entry.sv
// One buffer slot: valid, halt flag and payload with clear and load controls.
// Clear wins over load; only valid/halt are dropped on clear, payload stays stale.
module pipe_skid_entry #(
  parameter int DATA_W = 64
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clr_i,
  input  logic              load_i,
  input  logic              valid_i,
  input  logic              halt_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic              halt_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q;
  logic              halt_q;
  logic [DATA_W-1:0] data_q;

  always_ff @(negedge clk_i) begin
    if (rst_i) begin
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
      data_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
      halt_q  <= 1'b0;
    end else if (load_i) begin
      valid_q <= valid_i;
      halt_q  <= halt_i & valid_i;
      data_q  <= data_i;
    end
  end

  assign valid_o = valid_q;
  assign halt_o  = halt_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/ready handshake, optional skid slot,
// flush and halt-token blocking. State updates on the falling edge of CLK.
module pipe_stage_buf
  import pipe_pkg::*;
#(
  parameter int DATA_W     = 64,
  parameter bit SKID_EN    = 1'b1,
  parameter bit HALT_BLOCK = 1'b1
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_halt,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_halt,
  output logic              halted,
  output logic [1:0]        occupancy
);

  logic              main_v, main_h, skid_v, skid_h;
  logic [DATA_W-1:0] main_data, skid_data;
  logic              halted_q, halted_d;
  logic              blocked, in_xfer, out_xfer;
  logic              main_load, main_clr, main_from_skid, skid_load, skid_clr;
  logic              main_h_d;
  logic [DATA_W-1:0] main_data_d;

  always_comb begin
    blocked   = halted_q & HALT_BLOCK;
    // With the skid slot, ready depends on registered state only.
    in_ready  = (SKID_EN ? !skid_v : (!main_v | out_ready)) & !blocked;
    in_xfer   = in_valid & in_ready;
    out_xfer  = main_v & out_ready;

    main_from_skid = skid_v & out_xfer;
    main_load      = main_from_skid | (in_xfer & (!main_v | out_xfer));
    main_clr       = flush | (out_xfer & !main_load);
    main_h_d       = main_from_skid ? skid_h    : in_halt;
    main_data_d    = main_from_skid ? skid_data : in_data;

    skid_load = SKID_EN & in_xfer & main_v & !out_xfer;
    skid_clr  = flush | main_from_skid;

    halted_d = halted_q;
    if (flush) begin
      halted_d = 1'b0;
    end else if (in_xfer & in_halt) begin
      halted_d = 1'b1;
    end
  end

  always_ff @(negedge CLK) begin
    if (RST) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  pipe_skid_entry #(.DATA_W(DATA_W)) u_main (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (main_clr),
    .load_i  (main_load),
    .valid_i (1'b1),
    .halt_i  (main_h_d),
    .data_i  (main_data_d),
    .valid_o (main_v),
    .halt_o  (main_h),
    .data_o  (main_data)
  );

  pipe_skid_entry #(.DATA_W(DATA_W)) u_skid (
    .clk_i   (CLK),
    .rst_i   (RST),
    .clr_i   (skid_clr),
    .load_i  (skid_load),
    .valid_i (1'b1),
    .halt_i  (in_halt),
    .data_i  (in_data),
    .valid_o (skid_v),
    .halt_o  (skid_h),
    .data_o  (skid_data)
  );

  assign out_valid = main_v;
  assign out_data  = main_data;
  assign out_halt  = main_h & main_v;
  assign halted    = halted_q;
  assign occupancy = skid_v ? OCC_FULL : (main_v ? OCC_ONE : OCC_EMPTY);

endmodule
